// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing constants, framebuffer word layout and
//               3->8 bit colour expansion shared by the painter and scanout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int VGA_H_VISIBLE  = 640;
    localparam int VGA_H_FP       = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_H_TOTAL    = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_HS_START   = VGA_H_VISIBLE + VGA_H_FP;
    localparam int VGA_HS_END     = VGA_HS_START + VGA_H_SYNC - 1;

    localparam int VGA_V_VISIBLE  = 480;
    localparam int VGA_V_FP       = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_V_TOTAL    = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_VS_START   = VGA_V_VISIBLE + VGA_V_FP;
    localparam int VGA_VS_END     = VGA_VS_START + VGA_V_SYNC - 1;

    localparam int VGA_COLOR_DEPTH = 9;
    localparam int VGA_CH_W        = 3;
    localparam int VGA_ADDR_W      = 19;

    // Framebuffer word layout, MSB first: {R, G, B}
    typedef struct packed {
        logic [VGA_CH_W-1:0] r;
        logic [VGA_CH_W-1:0] g;
        logic [VGA_CH_W-1:0] b;
    } rgb333_t;

    function automatic logic [7:0] expand_3to8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_scanout_if.sv
// ============================================================================
// Module      : vga_scanout_if
// Description : Framebuffer read port between scanout (master) and RAM (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_scanout_if
    import vga_timing_pkg::*;
#(
    parameter int ADDR_W      = VGA_ADDR_W,
    parameter int COLOR_DEPTH = VGA_COLOR_DEPTH
);
    logic [ADDR_W-1:0]      fb_addr;
    logic                   fb_rd_en;
    logic [COLOR_DEPTH-1:0] fb_rdata;

    modport master (output fb_addr, output fb_rd_en, input fb_rdata);
    modport slave  (input fb_addr, input fb_rd_en, output fb_rdata);
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel enable, raster counters and raw sync/visible flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic clk,
    input  logic resetn,
    output logic pix_en_o,
    output logic hs_o,
    output logic vs_o,
    output logic visible_o,
    output logic vblank_start_o,
    output logic frame_last_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_C  = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_VISIBLE + H_FP);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_C  = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_VISIBLE + V_FP);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic           pix_en_q, pix_en_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    always_comb begin
        pix_en_d = ~pix_en_q;
        h_d      = h_q;
        v_d      = v_q;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            h_q      <= h_d;
            v_q      <= v_d;
        end
    end

    assign pix_en_o       = pix_en_q;
    assign visible_o      = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign hs_o           = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    assign vs_o           = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    assign vblank_start_o = pix_en_q && (h_q == '0) && (v_q == V_VIS_C);
    assign frame_last_o   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_scanout.sv
// ============================================================================
// Module      : vga_scanout
// Description : Raster-order framebuffer reader driving the VGA DAC pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int COLOR_DEPTH = VGA_COLOR_DEPTH,
    parameter int ADDR_W      = VGA_ADDR_W
) (
    input  logic           clk,
    input  logic           resetn,
    vga_scanout_if.master  fb,
    output logic [7:0]     VGA_R,
    output logic [7:0]     VGA_G,
    output logic [7:0]     VGA_B,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_N,
    output logic           VGA_SYNC_N,
    output logic           VGA_CLK,
    output logic           vblank_start
);

    logic pix_en, hs_s0, vs_s0, vis_s0, frame_last;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VISIBLE (V_VISIBLE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk            (clk),
        .resetn         (resetn),
        .pix_en_o       (pix_en),
        .hs_o           (hs_s0),
        .vs_o           (vs_s0),
        .visible_o      (vis_s0),
        .vblank_start_o (vblank_start),
        .frame_last_o   (frame_last)
    );

    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
    logic [COLOR_DEPTH-1:0] rdata_q, rdata_d;
    logic [7:0]             r_q, r_d, g_q, g_d, b_q, b_d;
    logic                   hs2_q, hs2_d, vs2_q, vs2_d, blank_n_q, blank_n_d;
    logic                   vga_clk_q;
    rgb333_t                px;

    assign px = rdata_q;

    always_comb begin
        addr_d    = addr_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        vis1_d    = vis1_q;
        rdata_d   = rdata_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs2_d     = hs2_q;
        vs2_d     = vs2_q;
        blank_n_d = blank_n_q;
        if (pix_en) begin
            if (frame_last)
                addr_d = '0;
            else if (vis_s0)
                addr_d = addr_q + 1'b1;
            hs1_d     = hs_s0;
            vs1_d     = vs_s0;
            vis1_d    = vis_s0;
            r_d       = vis1_q ? expand_3to8(px.r) : 8'h00;
            g_d       = vis1_q ? expand_3to8(px.g) : 8'h00;
            b_d       = vis1_q ? expand_3to8(px.b) : 8'h00;
            hs2_d     = hs1_q;
            vs2_d     = vs1_q;
            blank_n_d = vis1_q;
        end else begin
            // The RAM answers on the clk after the read, which is always a pix_en=0 clk
            rdata_d = fb.fb_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q    <= '0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            vis1_q    <= 1'b0;
            rdata_q   <= '0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            blank_n_q <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            vis1_q    <= vis1_d;
            rdata_q   <= rdata_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            blank_n_q <= blank_n_d;
            vga_clk_q <= ~pix_en;
        end
    end

    assign fb.fb_addr  = addr_q;
    assign fb.fb_rd_en = vis_s0 & pix_en;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
// ============================================================================
// Module      : tb_vga_scanout
// Description : Directed bench for vga_scanout on a reduced 32x12 raster.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scanout;

    localparam int HT        = 64;        // 32 + 16 + 8 + 8
    localparam int FRAME_PIX = HT * 19;   // 12 + 2 + 2 + 3 lines
    localparam logic [49:0] RST_EXP = {1'b0, 19'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, vblank_start;

    int cyc = 0;
    int vb_cnt = 0;
    int checks = 0;
    int errors = 0;

    vga_scanout_if #(.ADDR_W(19), .COLOR_DEPTH(9)) fb_if ();

    vga_scanout #(
        .H_VISIBLE (32), .H_FP (16), .H_SYNC (8), .H_BP (8),
        .V_VISIBLE (12), .V_FP (2),  .V_SYNC (2), .V_BP (3),
        .COLOR_DEPTH (9), .ADDR_W (19)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .fb           (fb_if),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .VGA_BLANK_N  (VGA_BLANK_N),
        .VGA_SYNC_N   (VGA_SYNC_N),
        .VGA_CLK      (VGA_CLK),
        .vblank_start (vblank_start)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= resetn ? cyc + 1 : 0;
    always @(negedge clk) if (vblank_start) vb_cnt <= vb_cnt + 1;

    function automatic logic [8:0] ram_word(input logic [18:0] a);
        return (a == 19'd5) ? 9'h1C5 : (a[8:0] ^ 9'h155);
    endfunction

    // Outside a read the RAM output drifts to all-ones so blanking must mask it
    always @(posedge clk)
        fb_if.fb_rdata <= fb_if.fb_rd_en ? ram_word(fb_if.fb_addr) : 9'h1FF;

    typedef struct {
        int         x, y, frame;
        logic       rd, vb;
        logic [18:0] addr;
        logic [7:0] r, g, b;
        logic       blank_n, hs, vs;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: cyc %0d, want %0d", cyc, n);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return VGA_HS;
            1:       return VGA_VS;
            2:       return VGA_BLANK_N;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input logic val, input int bound, output int n);
        n = 0;
        while (sig(s) !== val && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sig(s) !== val) begin
            checks++;
            errors++;
            $display("FAIL wait_for sig %0d: timeout after %0d clk", s, n);
        end
    endtask

    function automatic logic [49:0] pins_all();
        return {fb_if.fb_rd_en, fb_if.fb_addr, VGA_R, VGA_G, VGA_B,
                VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, vblank_start};
    endfunction

    initial begin
        int n, lo, hi, vb0;

        //          x   y  f  rd vb addr       R      G      B      BLK HS VS
        vecs[0]  = '{0,  0, 0, 1, 0, 19'd0,   8'hB6, 8'h49, 8'hB6, 1,  1, 1};
        vecs[1]  = '{5,  0, 0, 1, 0, 19'd5,   8'hFF, 8'h00, 8'hB6, 1,  1, 1};
        vecs[2]  = '{31, 0, 0, 1, 0, 19'd31,  8'hB6, 8'h24, 8'h49, 1,  1, 1};
        vecs[3]  = '{48, 0, 0, 0, 0, 19'd0,   8'h00, 8'h00, 8'h00, 0,  0, 1};
        vecs[4]  = '{55, 0, 0, 0, 0, 19'd0,   8'h00, 8'h00, 8'h00, 0,  0, 1};
        vecs[5]  = '{0,  1, 0, 1, 0, 19'd32,  8'hB6, 8'hDB, 8'hB6, 1,  1, 1};
        vecs[6]  = '{31, 11, 0, 1, 0, 19'd383, 8'h00, 8'hB6, 8'h49, 1, 1, 1};
        vecs[7]  = '{0,  12, 0, 0, 1, 19'd0,  8'h00, 8'h00, 8'h00, 0,  1, 1};
        vecs[8]  = '{0,  14, 0, 0, 0, 19'd0,  8'h00, 8'h00, 8'h00, 0,  1, 0};
        vecs[9]  = '{0,  16, 0, 0, 0, 19'd0,  8'h00, 8'h00, 8'h00, 0,  1, 1};
        vecs[10] = '{0,  0, 1, 1, 0, 19'd0,   8'hB6, 8'h49, 8'hB6, 1,  1, 1};
        vecs[11] = '{32, 0, 1, 0, 0, 19'd0,   8'h00, 8'h00, 8'h00, 0,  1, 1};
        vecs[12] = '{56, 0, 1, 0, 0, 19'd0,   8'h00, 8'h00, 8'h00, 0,  1, 1};
        vecs[13] = '{0,  15, 1, 0, 0, 19'd0,  8'h00, 8'h00, 8'h00, 0,  1, 0};

        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_values", pins_all(), RST_EXP);
        resetn = 1'b1;
        @(negedge clk);
        check("first_read", {fb_if.fb_rd_en, fb_if.fb_addr, VGA_CLK}, {1'b1, 19'd0, 1'b1});

        // S0 at odd cycle n reads the pixel; its pins are sampled 4 clk later
        for (int i = 0; i < 14; i++) begin
            n = 2 * (vecs[i].frame * FRAME_PIX + vecs[i].y * HT + vecs[i].x) + 1;
            wait_cyc(n);
            check($sformatf("s0_ctl[%0d]", i), {fb_if.fb_rd_en, vblank_start}, {vecs[i].rd, vecs[i].vb});
            if (vecs[i].rd)
                check($sformatf("s0_addr[%0d]", i), fb_if.fb_addr, vecs[i].addr);
            wait_cyc(n + 4);
            check($sformatf("pins[%0d]", i),
                  {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS},
                  {vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].blank_n, vecs[i].hs, vecs[i].vs});
        end

        for (int l = 0; l < 2; l++) begin
            wait_for(2, 1'b0, 3000, n);
            wait_for(2, 1'b1, 3000, n);
            check("rgb_at_blank_rise", |{VGA_R, VGA_G, VGA_B}, 1'b1);
            wait_for(2, 1'b0, 200, n);
            check("visible_clk", n, 64);
            wait_for(0, 1'b0, 200, n);
            check("blank_fall_to_hs_fall", n, 32);
        end

        wait_for(0, 1'b1, 200, n);
        wait_for(0, 1'b0, 200, n);
        for (int f = 0; f < 2; f++) begin
            wait_for(0, 1'b1, 200, lo);
            wait_for(0, 1'b0, 200, hi);
            check("hs_low_clk", lo, 16);
            check("hs_period_clk", lo + hi, 128);
        end

        wait_for(1, 1'b1, 5000, n);
        wait_for(1, 1'b0, 5000, n);
        for (int f = 0; f < 2; f++) begin
            vb0 = vb_cnt;
            wait_for(1, 1'b1, 5000, lo);
            wait_for(1, 1'b0, 5000, hi);
            check("vs_low_clk", lo, 256);
            check("vs_period_clk", lo + hi, 2432);
            check("vblank_per_frame", vb_cnt - vb0, 1);
        end

        // Restart cleanly, then reset for one clk at line 5, pixel 20
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        wait_cyc(2 * (5 * HT + 20) + 1);
        check("pre_reset_addr", {fb_if.fb_rd_en, fb_if.fb_addr}, {1'b1, 19'd180});
        resetn = 1'b0;
        @(negedge clk);
        check("midframe_reset", pins_all(), RST_EXP);
        resetn = 1'b1;
        @(negedge clk);
        check("restart_read", {fb_if.fb_rd_en, fb_if.fb_addr}, {1'b1, 19'd0});
        wait_for(0, 1'b0, 500, n);
        check("hs_phase_cyc", cyc, 100);
        wait_for(1, 1'b0, 3000, n);
        check("vs_phase_cyc", cyc, 1796);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_scanout.md
# vga_scanout

Read side of the snake-game framebuffer. The painter writes pixels into a 640x480, 9-bit dual-port RAM. This block reads that RAM back in raster order and drives the DE-series VGA DAC pins with 640x480@60 timing. Everything runs on the single 50 MHz system clock, using a 25 MHz pixel enable.

## Interface
Reset is synchronous and active-low; clock `clk`, reset `resetn`.

Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- `V_VISIBLE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths (lines)
- `COLOR_DEPTH`, 9, framebuffer word width; 3 bits per channel, {R,G,B}
- `ADDR_W`, 19, framebuffer address width

Ports:
- `clk`, in, 1, 50 MHz system clock
- `resetn`, in, 1, synchronous active-low reset
- `fb_addr`, out, ADDR_W, framebuffer read address
- `fb_rd_en`, out, 1, read strobe; RAM returns data exactly one clk later
- `fb_rdata`, in, COLOR_DEPTH, read data
- `VGA_R` / `VGA_G` / `VGA_B`, out, 8 each, DAC colour
- `VGA_HS` / `VGA_VS`, out, 1, active-low syncs
- `VGA_BLANK_N`, out, 1, high only during visible pixels
- `VGA_SYNC_N`, out, 1, tied 0
- `VGA_CLK`, out, 1, 25 MHz pixel clock to the DAC
- `vblank_start`, out, 1, one-clk pulse at the start of vertical blanking; the painter uses it as a safe-update marker

## Operation
- **Pixel enable:** `pix_en` toggles every clk, starting at 0 after reset. All counters and pipeline stages advance only when `pix_en` is 1. `VGA_CLK` is the registered inverse of `pix_en`, so the DAC samples mid-period.
- **Horizontal counter:** `h_cnt` runs 0..799 (H total 800) and wraps to 0.
- **Vertical counter:** `v_cnt` runs 0..524 (V total 525) and increments on the `h_cnt` wrap. Both counters wrap to 0 together at the end of the frame.
- **Visible region:** visible = `h_cnt` < 640 && `v_cnt` < 480.
- **Horizontal sync:** HS is low for `h_cnt` in [656, 751].
- **Vertical sync:** VS is low for `v_cnt` in [490, 491].
- **Address generation:** a running address counter, with no multiplier.
  - Cleared to 0 when the counters are at (0,0).
  - Incremented after each visible pixel.
  - `fb_addr` is the counter value for the current visible pixel, and `fb_rd_en` = visible && `pix_en`.
  - Address sequence: (x,y) → y*640 + x. The last address is 307199; the frame wrap returns it to 0.
- **Pipeline (pixel-enable stages):**
  - S0: counters and address issue.
  - S1: RAM data is valid. HS, VS and visible are delayed one stage.
  - S2: colour and syncs are registered to the pins.
- **Alignment:** HS, VS, BLANK_N and RGB are all delayed identically, so they stay mutually aligned.
- **Colour expansion:** each 3-bit channel c maps to 8 bits as {c, c, c[2:1]}; 3'b111 → 8'hFF, 3'b000 → 8'h00.
- **Blanking:** RGB is forced to 0 whenever the delayed visible flag is 0, regardless of `fb_rdata`.
- **`vblank_start`:** pulses for one clk when S0 reaches `h_cnt`=0, `v_cnt`=480 with `pix_en`=1. Once per frame.
- **Reset mid-frame:** on the next clk edge all state returns to reset values; scanout restarts at (0,0) with no partial-line artefacts beyond blank output.

## Timing
- **Reset values:** counters 0, `pix_en` 0, address 0, `fb_rd_en` 0, RGB 0, HS 1, VS 1, BLANK_N 0, `VGA_CLK` 0, `vblank_start` 0, pipeline valids 0.
- **Latency:** a counter value appears at the pins 2 pixel periods (4 clk) after S0. This is the RAM read latency (1 clk) plus output registers.
- **Line and frame timing:**
  - Line = 1600 clk; HS low for 192 clk per line.
  - Frame = 840000 clk; VS low for 3200 clk.
  - Visible per line = 1280 clk.
- **Read handshake:** no backpressure. The RAM must return data on the clk after `fb_rd_en`, and `fb_rdata` is sampled then.

## Structure
- **Shared package `vga_timing_pkg`:**
  - The 640x480 timing constants: totals, sync start/end and visible limits.
  - The `COLOR_DEPTH` / channel split.
  - The 3→8 bit expansion function.
  - The painter and the adapter use the same constants.
- **Sub-module `vga_timing_gen`:**
  - Contents: `pix_en`, `h_cnt` / `v_cnt`, raw HS/VS/visible, `vblank_start`.
  - The top of this block adds the address counter, the 2-stage pipeline and colour expansion.

## Test plan
- **Reset values:** hold `resetn`=0 for 5 clk → all outputs at the reset values above; release → first `fb_rd_en` on clk 1 with `fb_addr`=0.
- **Sync timing:** run 2 frames → HS period 1600 clk, low 192 clk; VS period 840000 clk, low 3200 clk; `vblank_start` exactly once per frame.
- **Address sequence:** pixel (639,0) → 639; (0,1) → 640; (639,479) → 307199; next frame's first read → 0. No reads during blanking.
- **Colour and alignment:** RAM model returns 9'b111_000_101 at address 5 → the pin sample for that pixel is R=FF, G=00, B=B6, with BLANK_N=1, 4 clk after the read. Blanking pixels show RGB=0 even with `fb_rdata`=9'h1FF.
- **Mid-frame reset:** assert `resetn`=0 at line 200, pixel 300 for 1 clk → the next clk shows reset values; the next frame starts at address 0 and HS/VS are phased from (0,0).
- **Pipeline alignment:** checker confirms BLANK_N rises on the same clk as the first nonzero RGB of each line, and HS falls 16 pixels after BLANK_N falls.
